apb_csr_slave: RTL and testbench

Parametrised APB slave that terminates the matrix-multiplier control bus and holds its control/status registers. Successor to the fixed 3-bit-address, 16-bit-data, zero-wait APB link: address/data widths, register count and access wait states are parameters, and it adds slave-error signalling, a self-clearing start pulse and a read-only status window. It sits between the APB master and the multiplier core, exposing configuration registers as flat outputs.

---
 rtl/apb_csr_slave.sv | 213 +++++++++++++++++++++
 tb/tb_apb_csr_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_csr_slave.sv
// APB slave holding the matrix-multiplier control/status registers.
// Optional feature: define APB_SLVERR_EN to flag illegal accesses on pslverr.
module apb_csr_slave #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 6,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [ADDR_W-1:0]              paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_W-1:0]              pwdata,
  output logic                           pready,
  output logic [DATA_W-1:0]              prdata,
  output logic                           pslverr,
  input  logic [DATA_W-1:0]              status_i,
  output logic                           start_o,
  output logic [DATA_W-1:0]              ctrl_o,
  output logic [(NUM_REGS-2)*DATA_W-1:0] cfg_o
);

  localparam int               NUM_CFG     = NUM_REGS - 32'sd2;
  localparam logic [ADDR_W:0]  NUM_REGS_L  = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [3:0]       WAIT_LOAD   = 4'(WAIT_CYCLES - 32'sd1);
  localparam bit               NO_WAIT     = (WAIT_CYCLES == 32'sd0);
  localparam logic [ADDR_W-1:0] ADDR_CTRL  = '0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_next_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                write_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                setup_s;
  logic [ADDR_W-1:0]   cur_addr_s;
  logic                cur_write_s;
  logic                illegal_s;
  logic [DATA_W-1:0]   rdata_s;
  logic                enter_done_s;
  logic                commit_s;
  logic [DATA_W-1:0]   ctrl_r;
  logic [DATA_W-1:0]   cfg_r [NUM_CFG];
  logic                start_r;
  logic                pready_r;
  logic [DATA_W-1:0]   prdata_r;

  assign setup_s = (state_r == ST_IDLE) && psel && !penable;

  // A zero-wait transfer decodes on the setup edge, before the latches hold it.
  assign cur_addr_s  = (state_r == ST_IDLE) ? paddr  : addr_r;
  assign cur_write_s = (state_r == ST_IDLE) ? pwrite : write_r;

  // FSM state and wait counter register
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (setup_s && NO_WAIT) begin
          state_next_s = ST_DONE;
        end else if (setup_s) begin
          state_next_s = ST_WAIT;
          cnt_next_s   = WAIT_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_next_s = ST_DONE;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // FSM outputs: completion strobe and write commit
  always_comb begin
    enter_done_s = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE: enter_done_s = setup_s && NO_WAIT;
      ST_WAIT: enter_done_s = psel && (cnt_r == 4'd0);
      ST_DONE: commit_s     = write_r && !illegal_s;
      default: begin
        enter_done_s = 1'b0;
        commit_s     = 1'b0;
      end
    endcase
  end

  // Address decode and read-data mux
  always_comb begin
    illegal_s = ({1'b0, cur_addr_s} >= NUM_REGS_L) ||
                (cur_write_s && (cur_addr_s == ADDR_STATUS));
    rdata_s   = '0;
    if (illegal_s || cur_write_s) begin
      rdata_s = '0;
    end else if (cur_addr_s == ADDR_CTRL) begin
      rdata_s = ctrl_r;
    end else if (cur_addr_s == ADDR_STATUS) begin
      rdata_s = status_i;
    end else begin
      for (int k = 0; k < NUM_CFG; k++) begin
        rdata_s = rdata_s |
                  ((cur_addr_s == ADDR_W'(k + 32'sd2)) ? cfg_r[k] : '0);
      end
    end
  end

  // Transfer capture at setup; later pwdata changes are ignored
  always_ff @(posedge pclk) begin
    if (preset) begin
      addr_r  <= '0;
      write_r <= 1'b0;
      wdata_r <= '0;
    end else if (setup_s) begin
      addr_r  <= paddr;
      write_r <= pwrite;
      wdata_r <= pwdata;
    end
  end

  // Register file commit and start pulse
  always_ff @(posedge pclk) begin
    if (preset) begin
      ctrl_r  <= '0;
      start_r <= 1'b0;
      for (int k = 0; k < NUM_CFG; k++) begin
        cfg_r[k] <= '0;
      end
    end else begin
      start_r <= commit_s && (addr_r == ADDR_CTRL) && wdata_r[0];
      if (commit_s && (addr_r == ADDR_CTRL)) begin
        ctrl_r <= {wdata_r[DATA_W-1:1], 1'b0};
      end
      for (int k = 0; k < NUM_CFG; k++) begin
        if (commit_s && (addr_r == ADDR_W'(k + 32'sd2))) begin
          cfg_r[k] <= wdata_r;
        end
      end
    end
  end

  // Registered bus response, zero outside the pready cycle
  always_ff @(posedge pclk) begin
    if (preset) begin
      pready_r <= 1'b0;
      prdata_r <= '0;
    end else begin
      pready_r <= enter_done_s;
      prdata_r <= enter_done_s ? rdata_s : '0;
    end
  end

`ifdef APB_SLVERR_EN
  logic pslverr_r;

  // Error flag travels with pready
  always_ff @(posedge pclk) begin
    if (preset) begin
      pslverr_r <= 1'b0;
    end else begin
      pslverr_r <= enter_done_s && illegal_s;
    end
  end

  assign pslverr = pslverr_r;
`else
  assign pslverr = 1'b0;
`endif

  assign pready  = pready_r;
  assign prdata  = prdata_r;
  assign start_o = start_r;
  assign ctrl_o  = ctrl_r;

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign cfg_o[g*DATA_W +: DATA_W] = cfg_r[g];
  end

endmodule

// File: tb/tb_apb_csr_slave.sv
// Scoreboard bench for apb_csr_slave (ADDR_W=3, DATA_W=16, NUM_REGS=6, WAIT_CYCLES=2).
module tb_apb_csr_slave;

  localparam int NREGS = 6;
  localparam int WAITC = 2;
`ifdef APB_SLVERR_EN
  localparam bit SLVERR = 1'b1;
`else
  localparam bit SLVERR = 1'b0;
`endif

  logic        pclk;
  logic        preset;
  logic [2:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] pwdata;
  logic        pready;
  logic [15:0] prdata;
  logic        pslverr;
  logic [15:0] status_i;
  logic        start_o;
  logic [15:0] ctrl_o;
  logic [63:0] cfg_o;

  apb_csr_slave #(.ADDR_W(3), .DATA_W(16), .NUM_REGS(NREGS), .WAIT_CYCLES(WAITC)) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .status_i(status_i), .start_o(start_o), .ctrl_o(ctrl_o),
    .cfg_o(cfg_o)
  );

  typedef struct {
    bit          is_read;
    logic [15:0] rdata;
    logic        err;
    int          setup_cyc;
    logic        start;
    logic [15:0] ctrl;
    logic [63:0] cfg;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [15:0] m_ctrl;
  logic [15:0] m_cfg [4];

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [63:0] model_cfg();
    return {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
  endfunction

  task automatic model_reset();
    m_ctrl = 16'h0000;
    for (int i = 0; i < 4; i++) m_cfg[i] = 16'h0000;
  endtask

  // Monitor: compares every completed transfer and the cycle after it
  logic        start_due = 1'b0;
  bit          post_due = 1'b0;
  logic [15:0] post_ctrl;
  logic [63:0] post_cfg;
  always @(negedge pclk) begin
    exp_t e;
    if (preset || !mon_en) begin
      start_due = 1'b0;
      post_due  = 1'b0;
    end else begin
      chk("start_o", {63'd0, start_o}, {63'd0, start_due});
      if (post_due) begin
        chk("ctrl_o", {48'd0, ctrl_o}, {48'd0, post_ctrl});
        chk("cfg_o", cfg_o, post_cfg);
      end
      start_due = 1'b0;
      post_due  = 1'b0;
      if (pready) begin
        if (q.size() == 0) begin
          chk("unexpected_pready", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("latency", 64'(cyc - e.setup_cyc), 64'(1 + WAITC));
          chk("pslverr", {63'd0, pslverr}, {63'd0, e.err});
          if (e.is_read) chk("prdata", {48'd0, prdata}, {48'd0, e.rdata});
          start_due = e.start;
          post_due  = 1'b1;
          post_ctrl = e.ctrl;
          post_cfg  = e.cfg;
        end
      end else begin
        chk("idle_bus", {47'd0, pslverr, prdata}, 64'd0);
      end
    end
  end

  // Full transfer; entered and left at posedge+1
  task automatic xfer(input bit wr, input int addr, input logic [15:0] data);
    exp_t e;
    bit   ill;
    bit   seen;
    ill       = (addr >= NREGS) || (wr && addr == 1);
    e.is_read = !wr;
    e.err     = SLVERR && ill;
    e.rdata   = 16'h0000;
    if (!wr && !ill) begin
      if (addr == 0) e.rdata = m_ctrl;
      else if (addr == 1) e.rdata = status_i;
      else e.rdata = m_cfg[addr-2];
    end
    if (wr && !ill) begin
      if (addr == 0) m_ctrl = data & 16'hFFFE;
      else m_cfg[addr-2] = data;
    end
    e.start     = wr && !ill && (addr == 0) && data[0];
    e.ctrl      = m_ctrl;
    e.cfg       = model_cfg();
    e.setup_cyc = cyc;
    q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 3'(addr); pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    pwdata  = 16'($urandom);
    seen    = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge pclk);
      seen = pready;
    end
    if (!seen) begin
      chk("pready_timeout", 64'd0, 64'd1);
      void'(q.pop_back());
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Write abandoned during WAIT: by dropping psel (kind 0) or by reset (kind 1)
  task automatic aborted_write(input int addr, input logic [15:0] data, input bit kind);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'(addr); pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    if (kind) preset = 1'b1;
    else begin psel = 1'b0; penable = 1'b0; end
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    if (kind) model_reset();
    repeat (4) @(posedge pclk);
    #1;
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 3'd0; pwdata = 16'h0000; status_i = 16'h0000;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_out", {pready, pslverr, start_o, prdata, ctrl_o}, 64'd0);
    chk("reset_cfg", cfg_o, 64'd0);
    preset = 1'b0;
    mon_en = 1'b1;

    xfer(1'b0, 2, 16'h0000);
    xfer(1'b1, 0, 16'h1235);
    xfer(1'b0, 0, 16'h0000);
    xfer(1'b1, 4, 16'hBEEF);
    xfer(1'b0, 4, 16'h0000);
    status_i = 16'h00A5;
    xfer(1'b0, 1, 16'h0000);
    xfer(1'b1, 1, 16'hFFFF);
    xfer(1'b0, 1, 16'h0000);
    xfer(1'b0, 7, 16'h0000);
    xfer(1'b1, 6, 16'h5555);

    aborted_write(3, 16'h1357, 1'b0);
    chk("abort_psel_cfg3", {48'd0, cfg_o[31:16]}, {48'd0, m_cfg[1]});
    chk("abort_psel_cfg", cfg_o, model_cfg());
    aborted_write(3, 16'h2468, 1'b1);
    chk("abort_rst_out", {pready, pslverr, start_o, prdata, ctrl_o}, 64'd0);
    chk("abort_rst_cfg", cfg_o, 64'd0);
    xfer(1'b0, 3, 16'h0000);

    for (int n = 0; n < 80; n++) begin
      status_i = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        penable = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b0;
      end
      xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom));
    end

    repeat (4) @(posedge pclk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
